// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types plus the L2 arbiter state encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } l2_arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/l2_arbiter_control.sv
// Arbitration FSM: picks I or D from IDLE, holds the grant until the L2 responds,
// and remembers the last winner for round-robin tie-breaks.
module l2_arbiter_control
  import lc3b_types::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq,
  input  logic dreq,
  input  logic l2_resp,
  output logic active,
  output logic sel_d
);

  l2_arb_state_t state_q, state_d;
  arb_src_t      last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= SRC_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        // A response seen here is spurious and deliberately ignored.
        if (ireq && dreq) begin
          if (RR_EN) state_d = (last_grant_q == SRC_I) ? ARB_SERVE_D : ARB_SERVE_I;
          else       state_d = ARB_SERVE_D;
        end else if (dreq) begin
          state_d = ARB_SERVE_D;
        end else if (ireq) begin
          state_d = ARB_SERVE_I;
        end
      end
      ARB_SERVE_I: begin
        if (l2_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = SRC_I;
        end
      end
      ARB_SERVE_D: begin
        if (l2_resp) begin
          state_d      = ARB_IDLE;
          last_grant_d = SRC_D;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign active = (state_q != ARB_IDLE);
  assign sel_d  = (state_q == ARB_SERVE_D);

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache; routing is purely
// combinational from the registered grant so the L2 strobe follows the grant cycle.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word i_mem_addr,
  input  logic     i_mem_read,
  output lc3b_line i_mem_rdata,
  output logic     i_mem_resp,
  input  lc3b_word d_mem_addr,
  input  lc3b_line d_mem_wdata,
  input  logic     d_mem_read,
  input  logic     d_mem_write,
  output lc3b_line d_mem_rdata,
  output logic     d_mem_resp,
  output lc3b_word l2_mem_addr,
  output lc3b_line l2_mem_wdata,
  output logic     l2_mem_read,
  output logic     l2_mem_write,
  input  lc3b_line l2_mem_rdata,
  input  logic     l2_mem_resp
);

  logic active, sel_d;
  logic serve_i, serve_d;

  l2_arbiter_control #(.RR_EN(RR_EN)) u_control (
    .clk     (clk),
    .reset   (reset),
    .ireq    (i_mem_read),
    .dreq    (d_mem_read | d_mem_write),
    .l2_resp (l2_mem_resp),
    .active  (active),
    .sel_d   (sel_d)
  );

  assign serve_i = active & ~sel_d;
  assign serve_d = active & sel_d;

  always_comb begin
    l2_mem_addr  = '0;
    l2_mem_wdata = '0;
    l2_mem_read  = 1'b0;
    l2_mem_write = 1'b0;
    if (serve_d) begin
      l2_mem_addr  = d_mem_addr;
      l2_mem_wdata = d_mem_wdata;
      l2_mem_read  = d_mem_read;
      l2_mem_write = d_mem_write;
    end else if (serve_i) begin
      l2_mem_addr  = i_mem_addr;
      l2_mem_read  = i_mem_read;
    end
  end

  // Data is broadcast; each requester qualifies it with its own resp.
  assign i_mem_rdata = l2_mem_rdata;
  assign d_mem_rdata = l2_mem_rdata;
  assign i_mem_resp  = serve_i & l2_mem_resp;
  assign d_mem_resp  = serve_d & l2_mem_resp;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: index 0 is the fixed-D-priority instance, index 1 round-robin.
module tb_l2_arbiter;
  import lc3b_types::*;

  logic     clk = 1'b0;
  logic     reset = 1'b1;
  lc3b_word i_addr = '0;
  logic     i_read = 1'b0;
  lc3b_word d_addr = '0;
  lc3b_line d_wdata = '0;
  logic     d_read = 1'b0;
  logic     d_write = 1'b0;
  lc3b_line l2_rdata = '0;
  logic     l2_resp = 1'b0;

  lc3b_line ird  [2];
  lc3b_line drd  [2];
  logic     iresp[2];
  logic     dresp[2];
  lc3b_word l2a  [2];
  lc3b_line l2wd [2];
  logic     l2r  [2];
  logic     l2w  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_arbiter #(.RR_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .i_mem_addr(i_addr), .i_mem_read(i_read), .i_mem_rdata(ird[0]), .i_mem_resp(iresp[0]),
    .d_mem_addr(d_addr), .d_mem_wdata(d_wdata), .d_mem_read(d_read), .d_mem_write(d_write),
    .d_mem_rdata(drd[0]), .d_mem_resp(dresp[0]),
    .l2_mem_addr(l2a[0]), .l2_mem_wdata(l2wd[0]), .l2_mem_read(l2r[0]), .l2_mem_write(l2w[0]),
    .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp)
  );

  l2_arbiter #(.RR_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset),
    .i_mem_addr(i_addr), .i_mem_read(i_read), .i_mem_rdata(ird[1]), .i_mem_resp(iresp[1]),
    .d_mem_addr(d_addr), .d_mem_wdata(d_wdata), .d_mem_read(d_read), .d_mem_write(d_write),
    .d_mem_rdata(drd[1]), .d_mem_resp(dresp[1]),
    .l2_mem_addr(l2a[1]), .l2_mem_wdata(l2wd[1]), .l2_mem_read(l2r[1]), .l2_mem_write(l2w[1]),
    .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp)
  );

  function automatic lc3b_line rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    i_read = 1'b1; i_addr = 16'h1111;
    d_write = 1'b1; d_addr = 16'h4000; d_wdata = rand_line();
    l2_resp = 1'b1; l2_rdata = rand_line();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({l2r[k], l2w[k], iresp[k], dresp[k]} !== 4'b0 || l2a[k] !== '0 || l2wd[k] !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d got rd=%b wr=%b iresp=%b dresp=%b addr=%h expected all 0",
                 k, l2r[k], l2w[k], iresp[k], dresp[k], l2a[k]);
      end
      checks++;
      if (ird[k] !== l2_rdata || drd[k] !== l2_rdata) begin
        failures++;
        $display("FAIL rdata_passthru dut%0d got i=%h d=%h expected %h", k, ird[k], drd[k], l2_rdata);
      end
    end
  endtask

  task automatic test_i_read();
    lc3b_line rd;
    do_reset();
    i_addr = 16'h1230; i_read = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (l2r[k] !== 1'b0) begin
        failures++;
        $display("FAIL i_read_cycle0 dut%0d got rd=%b expected 0", k, l2r[k]);
      end
    end
    for (int cyc = 1; cyc <= 4; cyc++) begin
      step();
      l2_resp = (cyc == 4);
      rd = rand_line();
      l2_rdata = rd;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (l2a[k] !== 16'h1230 || l2r[k] !== 1'b1 || l2w[k] !== 1'b0) begin
          failures++;
          $display("FAIL i_read_strobe dut%0d cyc%0d got addr=%h rd=%b wr=%b expected 1230/1/0",
                   k, cyc, l2a[k], l2r[k], l2w[k]);
        end
        checks++;
        if (iresp[k] !== (cyc == 4) || dresp[k] !== 1'b0) begin
          failures++;
          $display("FAIL i_read_resp dut%0d cyc%0d got iresp=%b dresp=%b expected %0d/0",
                   k, cyc, iresp[k], dresp[k], (cyc == 4));
        end
      end
      if (cyc == 4) begin
        checks++;
        if (ird[1] !== rd) begin
          failures++;
          $display("FAIL i_read_data got %h expected %h", ird[1], rd);
        end
      end
    end
    step();
    i_read = 1'b0; l2_resp = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (l2a[k] !== '0 || l2r[k] !== 1'b0 || iresp[k] !== 1'b0) begin
        failures++;
        $display("FAIL i_read_idle_after dut%0d got addr=%h rd=%b iresp=%b expected 0/0/0",
                 k, l2a[k], l2r[k], iresp[k]);
      end
    end
  endtask

  task automatic test_d_write();
    lc3b_line wd;
    wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBEEF;
    do_reset();
    d_addr = 16'h4000; d_wdata = wd; d_write = 1'b1;
    for (int cyc = 1; cyc <= 2; cyc++) begin
      step();
      l2_resp = (cyc == 2);
      #1;
      checks++;
      if (l2a[1] !== 16'h4000 || l2w[1] !== 1'b1 || l2r[1] !== 1'b0 || l2wd[1] !== wd) begin
        failures++;
        $display("FAIL d_write_strobe cyc%0d got addr=%h wr=%b rd=%b wdata=%h", cyc, l2a[1], l2w[1], l2r[1], l2wd[1]);
      end
      checks++;
      if (dresp[1] !== (cyc == 2) || iresp[1] !== 1'b0) begin
        failures++;
        $display("FAIL d_write_resp cyc%0d got dresp=%b iresp=%b expected %0d/0", cyc, dresp[1], iresp[1], (cyc == 2));
      end
    end
    step();
    d_write = 1'b0;
    #1;
    checks++;
    if (dresp[1] !== 1'b0 || l2w[1] !== 1'b0 || l2wd[1] !== '0) begin
      failures++;
      $display("FAIL d_write_single_pulse got dresp=%b wr=%b wdata=%h expected 0", dresp[1], l2w[1], l2wd[1]);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    l2_resp = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (iresp[k] !== 1'b0 || dresp[k] !== 1'b0 || l2r[k] !== 1'b0 || l2w[k] !== 1'b0) begin
          failures++;
          $display("FAIL spurious_resp dut%0d got iresp=%b dresp=%b rd=%b wr=%b expected 0",
                   k, iresp[k], dresp[k], l2r[k], l2w[k]);
        end
      end
      step();
    end
    l2_resp = 1'b0; d_addr = 16'h2222; d_read = 1'b1;
    step();
    #1;
    checks++;
    if (l2a[1] !== 16'h2222 || l2r[1] !== 1'b1) begin
      failures++;
      $display("FAIL spurious_then_grant got addr=%h rd=%b expected 2222/1", l2a[1], l2r[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit exp_d;
    do_reset();
    i_addr = 16'h0010; i_read = 1'b1;
    d_addr = 16'h8000; d_read = 1'b1;
    for (int c = 0; c < 30; c++) begin
      l2_resp = ((c % 3) == 2);
      exp_d = ((c / 3) % 2) == 0;
      #1;
      if ((c % 3) == 0) begin
        checks++;
        if (l2r[1] !== 1'b0 || l2r[0] !== 1'b0 || l2a[1] !== '0) begin
          failures++;
          $display("FAIL b2b_idle c%0d got rd1=%b rd0=%b addr1=%h expected idle", c, l2r[1], l2r[0], l2a[1]);
        end
      end else begin
        checks++;
        if (l2a[1] !== (exp_d ? 16'h8000 : 16'h0010) || l2r[1] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_rr_grant c%0d got addr=%h rd=%b expected %s", c, l2a[1], l2r[1], exp_d ? "D" : "I");
        end
        checks++;
        if (l2a[0] !== 16'h8000 || l2r[0] !== 1'b1 || iresp[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_fixed_grant c%0d got addr=%h rd=%b iresp=%b expected D", c, l2a[0], l2r[0], iresp[0]);
        end
      end
      if ((c % 3) == 2) begin
        checks++;
        if (dresp[1] !== exp_d || iresp[1] !== !exp_d || dresp[0] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_resp c%0d got dresp1=%b iresp1=%b dresp0=%b", c, dresp[1], iresp[1], dresp[0]);
        end
      end
      step();
    end
    l2_resp = 1'b0; d_read = 1'b0;
    step();
    #1;
    checks++;
    if (l2a[0] !== 16'h0010 || l2r[0] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_i_when_d_idle got addr=%h rd=%b expected 0010/1", l2a[0], l2r[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_addr = 16'h4444; d_read = 1'b1;
    step();
    l2_resp = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (l2r[k] !== 1'b1 || dresp[k] !== 1'b1) begin
        failures++;
        $display("FAIL mid_pre_reset dut%0d got rd=%b dresp=%b expected 1/1", k, l2r[k], dresp[k]);
      end
    end
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (l2r[k] !== 1'b0 || l2w[k] !== 1'b0 || dresp[k] !== 1'b0 || iresp[k] !== 1'b0) begin
        failures++;
        $display("FAIL mid_async_reset dut%0d got rd=%b wr=%b dresp=%b iresp=%b expected 0",
                 k, l2r[k], l2w[k], dresp[k], iresp[k]);
      end
    end
    @(negedge clk);
    l2_resp = 1'b0; i_addr = 16'h0010; i_read = 1'b1; d_addr = 16'h8000; d_read = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (l2a[k] !== 16'h8000 || l2r[k] !== 1'b1) begin
        failures++;
        $display("FAIL mid_tie_after_reset dut%0d got addr=%h rd=%b expected 8000/1", k, l2a[k], l2r[k]);
      end
    end
  endtask

  // Reference: owner 0=none 1=I 2=D; requesters hold until their resp.
  task automatic test_random(input int which);
    int owner, last, nxt;
    bit ipend, dpend, dwr;
    bit e_rd, e_wr, e_ir, e_dr;
    lc3b_word e_a;
    lc3b_line e_wd;
    do_reset();
    owner = 0; last = 1; ipend = 0; dpend = 0; dwr = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!ipend && ($urandom_range(2) == 0)) begin
        ipend = 1; i_addr = 16'($urandom);
      end
      if (!dpend && ($urandom_range(2) == 0)) begin
        dpend = 1; d_addr = 16'($urandom); d_wdata = rand_line(); dwr = $urandom_range(1) == 1;
      end
      i_read = ipend;
      d_read = dpend && !dwr;
      d_write = dpend && dwr;
      l2_resp = ($urandom_range(2) == 0);
      l2_rdata = rand_line();
      #1;
      e_a = '0; e_wd = '0; e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0;
      if (owner == 1) begin
        e_a = i_addr; e_rd = i_read; e_ir = l2_resp;
      end else if (owner == 2) begin
        e_a = d_addr; e_wd = d_wdata; e_rd = d_read; e_wr = d_write; e_dr = l2_resp;
      end
      checks++;
      if (l2a[which] !== e_a || l2wd[which] !== e_wd || l2r[which] !== e_rd || l2w[which] !== e_wr) begin
        failures++;
        $display("FAIL rand_bus dut%0d cyc%0d got addr=%h rd=%b wr=%b expected addr=%h rd=%b wr=%b",
                 which, cyc, l2a[which], l2r[which], l2w[which], e_a, e_rd, e_wr);
      end
      checks++;
      if (iresp[which] !== e_ir || dresp[which] !== e_dr || ird[which] !== l2_rdata || drd[which] !== l2_rdata) begin
        failures++;
        $display("FAIL rand_resp dut%0d cyc%0d got iresp=%b dresp=%b expected %b/%b",
                 which, cyc, iresp[which], dresp[which], e_ir, e_dr);
      end
      if (e_ir) ipend = 0;
      if (e_dr) dpend = 0;
      nxt = owner;
      if (owner == 0) begin
        if (i_read && (d_read || d_write)) nxt = (which == 1) ? 3 - last : 2;
        else if (d_read || d_write)        nxt = 2;
        else if (i_read)                   nxt = 1;
      end else if (l2_resp) begin
        last = owner;
        nxt = 0;
      end
      @(posedge clk);
      owner = nxt;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    test_random(1);
    test_random(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
